int_accept_ctrl: RTL

INT_ACCEPT_CTRL -- requirements
Module: int_accept_ctrl

---
 rtl/int_accept_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/int_accept_ctrl.sv
// Interrupt acceptance controller: accepts normal/urgent requests, redirects the
// pipeline at an instruction boundary, acknowledges the requester and tracks nesting.
module int_accept_ctrl #(
  parameter logic [31:0] VEC_NORMAL  = 32'h0000_0008,
  parameter logic [31:0] VEC_URGENT  = 32'h0000_0004,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic        K_IntReq,
  input  logic        K_IntID,
  output logic        I_IntAck,
  input  logic        IntEnable,
  input  logic        InstrBoundary,
  input  logic        IntReturn,
  output logic        IntTake,
  output logic [31:0] IntVector,
  output logic [1:0]  InService,
  output logic        AckTimeoutErr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    ACK       = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t      state, stateNext;
  logic        pendId, pendIdNext;
  logic [3:0]  dropCnt, dropCntNext;
  logic [1:0]  inService, inServiceNext, svcAfterReturn;
  logic        ackErr, ackErrNext;
  logic        armed;
  logic        upgrade;

  // Urgent only needs the urgent slot free; normal also needs interrupts enabled
  // and nothing in service at all.
  function automatic logic acceptable(input logic cls, input logic [1:0] svc,
                                      input logic enable);
    return cls ? !svc[1] : (enable && (svc == 2'b00));
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    stateNext      = state;
    pendIdNext     = pendId;
    dropCntNext    = dropCnt;
    ackErrNext     = ackErr;
    IntTake        = 1'b0;
    IntVector      = '0;
    I_IntAck       = 1'b0;
    upgrade        = 1'b0;

    // A return retires the most recently accepted level before any new take is recorded.
    svcAfterReturn = inService;
    if (IntReturn) begin
      if (inService[1]) svcAfterReturn = {1'b0, inService[0]};
      else              svcAfterReturn = 2'b00;
    end

    case (state)
      IDLE: begin
        // armed holds off acceptance for one edge after reset release.
        if (armed && K_IntReq && acceptable(K_IntID, inService, IntEnable)) begin
          stateNext  = PENDING;
          pendIdNext = K_IntID;
        end
      end

      PENDING: begin
        IntVector = pendId ? VEC_URGENT : VEC_NORMAL;
        upgrade   = K_IntReq && !pendId && K_IntID;
        if (!K_IntReq || !acceptable(pendId, inService, IntEnable)) begin
          stateNext = IDLE;
        end else if (upgrade) begin
          // Switching to the urgent vector costs a cycle so the vector never changes under a take.
          pendIdNext = 1'b1;
        end else if (InstrBoundary) begin
          IntTake   = 1'b1;
          stateNext = ACK;
        end
      end

      ACK: begin
        I_IntAck    = 1'b1;
        stateNext   = WAIT_DROP;
        dropCntNext = 4'(ACK_TIMEOUT);
      end

      WAIT_DROP: begin
        if (!K_IntReq) begin
          stateNext   = IDLE;
          dropCntNext = '0;
        end else begin
          dropCntNext = dropCnt - 4'd1;
          if (dropCnt <= 4'd1) begin
            dropCntNext = '0;
            ackErrNext  = 1'b1;
            stateNext   = IDLE;
          end
        end
      end

      default: stateNext = IDLE;
    endcase

    inServiceNext = svcAfterReturn;
    if (IntTake) inServiceNext[pendId] = 1'b1;
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      state     <= IDLE;
      pendId    <= 1'b0;
      dropCnt   <= '0;
      inService <= 2'b00;
      ackErr    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= stateNext;
      pendId    <= pendIdNext;
      dropCnt   <= dropCntNext;
      inService <= inServiceNext;
      ackErr    <= ackErrNext;
      armed     <= 1'b1;
    end
  end

  assign InService     = inService;
  assign AckTimeoutErr = ackErr;

endmodule
